// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: widths, iteration count
// and FSM state encodings.
package conversor_bcd_pkg;

    localparam int unsigned ITERACOES = 8;
    localparam int unsigned LARG_BCD  = 4;
    localparam int unsigned LARG_BIN  = 8;
    localparam int unsigned LARG_REG  = 3 * LARG_BCD + LARG_BIN;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONVERTE = 2'b01,
        FIM      = 2'b10
    } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
module ajuste_bcd
    import conversor_bcd_pkg::*;
(
    input  logic [LARG_BCD-1:0] entrada,
    output logic [LARG_BCD-1:0] saida
);

    always_comb begin
        saida = entrada;
        if (entrada >= LARG_BCD'(5)) begin
            saida = entrada + LARG_BCD'(3);
        end
    end

endmodule

// File: rtl/conversor_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3), fixed
// 9-clock latency from the accepting edge to the result edge.
module conversor_bcd
    import conversor_bcd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inicio,
    input  logic [LARG_BIN-1:0] binario,
    output logic [LARG_BCD-1:0] centena,
    output logic [LARG_BCD-1:0] dezena,
    output logic [LARG_BCD-1:0] unidade,
    output logic                ocupado,
    output logic                pronto
);

    estado_t             estado_q;
    logic [2:0]          cont_q;
    logic [LARG_REG-1:0] trab_q;

    logic [LARG_BCD-1:0] cen_aj, dez_aj, uni_aj;
    logic [LARG_REG-1:0] ajustado;
    logic [LARG_REG-1:0] deslocado;

    // Working register layout: {cen[19:16], dez[15:12], uni[11:8], bin[7:0]}
    ajuste_bcd u_ajuste_cen (
        .entrada (trab_q[19:16]),
        .saida   (cen_aj)
    );

    ajuste_bcd u_ajuste_dez (
        .entrada (trab_q[15:12]),
        .saida   (dez_aj)
    );

    ajuste_bcd u_ajuste_uni (
        .entrada (trab_q[11:8]),
        .saida   (uni_aj)
    );

    always_comb begin
        ajustado  = {cen_aj, dez_aj, uni_aj, trab_q[LARG_BIN-1:0]};
        deslocado = {ajustado[LARG_REG-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            cont_q   <= 3'd0;
            trab_q   <= '0;
            centena  <= '0;
            dezena   <= '0;
            unidade  <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        trab_q   <= {{(3 * LARG_BCD){1'b0}}, binario};
                        cont_q   <= 3'd0;
                        ocupado  <= 1'b1;
                        estado_q <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    trab_q <= deslocado;
                    cont_q <= cont_q + 3'd1;
                    if (cont_q == 3'(ITERACOES - 1)) begin
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    centena  <= trab_q[19:16];
                    dezena   <= trab_q[15:12];
                    unidade  <= trab_q[11:8];
                    pronto   <= 1'b1;
                    ocupado  <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    ocupado  <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: directed vector table, multi-cycle
// corner sequences and a full 0..255 sweep.
module tb_conversor_bcd;

    logic       clk;
    logic       rst_n;
    logic       inicio;
    logic [7:0] binario;
    logic [3:0] centena, dezena, unidade;
    logic       ocupado, pronto;

    int errors = 0;
    int checks = 0;

    conversor_bcd dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .binario (binario),
        .centena (centena),
        .dezena  (dezena),
        .unidade (unidade),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] valor;
        int         cen;
        int         dez;
        int         uni;
    } vetor_t;

    vetor_t tabela[12];

    task automatic check(input string nome, input logic [31:0] atual,
                         input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic checa_dig(input string nome, input int c, input int d, input int u);
        check({nome, " centena"}, 32'(centena), 32'(c));
        check({nome, " dezena"}, 32'(dezena), 32'(d));
        check({nome, " unidade"}, 32'(unidade), 32'(u));
    endtask

    // Starts a conversion and waits (bounded) for pronto; lat counts edges after T0.
    task automatic converte(input logic [7:0] v, output int lat, output logic ocup_ok);
        @(negedge clk);
        binario = v;
        inicio  = 1'b1;
        @(posedge clk);
        #1;
        inicio  = 1'b0;
        binario = ~v;
        lat     = 0;
        ocup_ok = 1'b1;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (pronto) break;
            if (!ocupado) ocup_ok = 1'b0;
        end
        if (pronto && ocupado) ocup_ok = 1'b0;
    endtask

    task automatic conta_pronto(input int ciclos, output int n);
        n = 0;
        for (int k = 0; k < ciclos; k++) begin
            @(posedge clk);
            #1;
            if (pronto) n++;
        end
    endtask

    int   lat;
    int   npr;
    int   primeiro;
    logic ocup_ok;
    logic [3:0] c_cap, d_cap, u_cap;

    initial begin
        tabela[0]  = '{8'd0,   0, 0, 0};
        tabela[1]  = '{8'd255, 2, 5, 5};
        tabela[2]  = '{8'd37,  0, 3, 7};
        tabela[3]  = '{8'd200, 2, 0, 0};
        tabela[4]  = '{8'd99,  0, 9, 9};
        tabela[5]  = '{8'd64,  0, 6, 4};
        tabela[6]  = '{8'd128, 1, 2, 8};
        tabela[7]  = '{8'd1,   0, 0, 1};
        tabela[8]  = '{8'd9,   0, 0, 9};
        tabela[9]  = '{8'd10,  0, 1, 0};
        tabela[10] = '{8'd100, 1, 0, 0};
        tabela[11] = '{8'd199, 1, 9, 9};

        rst_n   = 1'b0;
        inicio  = 1'b0;
        binario = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checa_dig("reset", 0, 0, 0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("idle ocupado", 32'(ocupado), 32'd0);
        check("idle pronto", 32'(pronto), 32'd0);

        for (int i = 0; i < 12; i++) begin
            converte(tabela[i].valor, lat, ocup_ok);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
            check($sformatf("vec%0d ocupado", i), 32'(ocup_ok), 32'd1);
            checa_dig($sformatf("vec%0d", i), tabela[i].cen, tabela[i].dez, tabela[i].uni);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pronto width", i), 32'(pronto), 32'd0);
            checa_dig($sformatf("vec%0d hold", i), tabela[i].cen, tabela[i].dez, tabela[i].uni);
        end

        // Back-to-back: inicio held high through the pronto cycle.
        @(negedge clk);
        binario = 8'd37;
        inicio  = 1'b1;
        @(posedge clk);
        #1;
        binario = 8'd200;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (pronto) break;
        end
        check("b2b first latency", 32'(lat), 32'd9);
        checa_dig("b2b first", 0, 3, 7);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (pronto) break;
        end
        inicio = 1'b0;
        check("b2b pronto spacing", 32'(lat), 32'd10);
        checa_dig("b2b second", 2, 0, 0);
        @(posedge clk);
        #1;
        check("b2b idle after", 32'(ocupado), 32'd0);

        // inicio re-pulsed mid-conversion must be ignored.
        @(negedge clk);
        binario = 8'd99;
        inicio  = 1'b1;
        @(posedge clk);
        #1;
        inicio  = 1'b0;
        binario = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        inicio  = 1'b1;
        binario = 8'd11;
        @(posedge clk);
        #1;
        inicio   = 1'b0;
        npr      = 0;
        primeiro = 0;
        for (int e = 5; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (pronto) begin
                npr++;
                if (primeiro == 0) begin
                    primeiro = e;
                    c_cap = centena;
                    d_cap = dezena;
                    u_cap = unidade;
                end
            end
        end
        check("ignore pronto edge", 32'(primeiro), 32'd9);
        check("ignore pronto count", 32'(npr), 32'd1);
        check("ignore centena", 32'(c_cap), 32'd0);
        check("ignore dezena", 32'(d_cap), 32'd9);
        check("ignore unidade", 32'(u_cap), 32'd9);

        // Reset in the middle of a conversion.
        converte(8'd128, lat, ocup_ok);
        checa_dig("pre-abort", 1, 2, 8);
        @(negedge clk);
        binario = 8'd77;
        inicio  = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checa_dig("abort", 0, 0, 0);
        check("abort pronto", 32'(pronto), 32'd0);
        check("abort ocupado", 32'(ocupado), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        conta_pronto(15, npr);
        check("abort no pronto", 32'(npr), 32'd0);
        checa_dig("abort hold", 0, 0, 0);
        converte(8'd64, lat, ocup_ok);
        check("after abort latency", 32'(lat), 32'd9);
        checa_dig("after abort", 0, 6, 4);

        for (int v = 0; v < 256; v++) begin
            converte(8'(v), lat, ocup_ok);
            check($sformatf("sweep %0d latency", v), 32'(lat), 32'd9);
            checa_dig($sformatf("sweep %0d", v), v / 100, (v / 10) % 10, v % 10);
            check($sformatf("sweep %0d bcd valid", v),
                  32'((centena <= 4'd9) && (dezena <= 4'd9) && (unidade <= 4'd9)), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
